// File: rtl/famicom_pkg.sv
// famicom_pkg: shared definitions for the Famicom bus blocks.
//   dma_state_t  - OAM DMA controller FSM states
//   OAM_DMA_REG  - CPU register that starts a sprite DMA (write page number)
//   OAMDATA_REG  - PPU OAM data port that the DMA writes into
package famicom_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HALT,
      ST_ALIGN,
      ST_READ,
      ST_WRITE
   } dma_state_t;

   localparam logic [15:0] OAM_DMA_REG = 16'h4014;
   localparam logic [15:0] OAMDATA_REG = 16'h2004;

endpackage

// File: rtl/oam_dma_controller_if.sv
// oam_dma_controller_if: CPU-side and system-bus signals of the OAM DMA.
//   cpu_addr/cpu_data_out/cpu_write/cpu_read_cycle - CPU bus cycle in progress
//   bus_data_in                                     - memory read data
//   rdy                                             - CPU ready (0 stalls)
//   bus_addr/bus_data_out/bus_write                 - muxed system bus
//   dma_active                                      - DMA owns the bus
// modport slave is the DMA controller, modport master is the CPU/memory side.
interface oam_dma_controller_if;

   logic [15:0] cpu_addr;
   logic [7:0]  cpu_data_out;
   logic        cpu_write;
   logic        cpu_read_cycle;
   logic [7:0]  bus_data_in;
   logic        rdy;
   logic [15:0] bus_addr;
   logic [7:0]  bus_data_out;
   logic        bus_write;
   logic        dma_active;

   modport slave (
      input  cpu_addr, cpu_data_out, cpu_write, cpu_read_cycle, bus_data_in,
      output rdy, bus_addr, bus_data_out, bus_write, dma_active
   );

   modport master (
      output cpu_addr, cpu_data_out, cpu_write, cpu_read_cycle, bus_data_in,
      input  rdy, bus_addr, bus_data_out, bus_write, dma_active
   );

endinterface

// File: rtl/cpu_cycle_parity.sv
// cpu_cycle_parity: tracks get/put alternation of CPU cycles.
//   sys_clock    - system clock
//   rst          - synchronous active-low reset (parity -> 0)
//   clk_phase_1  - CPU-cycle strobe; parity toggles on each strobed edge
//   cycle_parity - 0 = get cycle, 1 = put cycle
module cpu_cycle_parity (
   input  logic sys_clock,
   input  logic rst,
   input  logic clk_phase_1,
   output logic cycle_parity
);

   always_ff @(posedge sys_clock) begin
      if (!rst) begin
         cycle_parity <= 1'b0;
      end else if (clk_phase_1) begin
         cycle_parity <= ~cycle_parity;
      end
   end

endmodule

// File: rtl/oam_dma_controller.sv
// oam_dma_controller: sprite DMA ($4014). A CPU write of page P to $4014
// halts the CPU on its next read cycle, optionally spends one alignment
// cycle, then copies P00..PFF into $2004 as 256 read/write pairs.
//   sys_clock   - system clock
//   rst         - synchronous active-low reset
//   clk_phase_1 - CPU-cycle strobe; all state advances only when high
//   dma_bus     - CPU/system bus signals (see oam_dma_controller_if)
module oam_dma_controller
   import famicom_pkg::*;
(
   input  logic                 sys_clock,
   input  logic                 rst,
   input  logic                 clk_phase_1,
   oam_dma_controller_if.slave  dma_bus
);

   dma_state_t  state;
   dma_state_t  state_nxt;
   logic [7:0]  page;
   logic [7:0]  count;
   logic [7:0]  data_latch;
   logic        rdy_q;
   logic        cycle_parity;
   logic        trigger;

   cpu_cycle_parity u_cycle_parity (
      .sys_clock    (sys_clock),
      .rst          (rst),
      .clk_phase_1  (clk_phase_1),
      .cycle_parity (cycle_parity)
   );

   assign trigger     = dma_bus.cpu_write && (dma_bus.cpu_addr == OAM_DMA_REG);
   assign dma_bus.rdy = rdy_q;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (trigger) state_nxt = ST_HALT;
         // Parity after this edge is ~cycle_parity; reads must land on get
         // cycles, so a put-parity halt cycle goes straight to READ.
         ST_HALT:  if (dma_bus.cpu_read_cycle) state_nxt = cycle_parity ? ST_READ : ST_ALIGN;
         ST_ALIGN: state_nxt = ST_READ;
         ST_READ:  state_nxt = ST_WRITE;
         ST_WRITE: state_nxt = (count == 8'hFF) ? ST_IDLE : ST_READ;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge sys_clock) begin
      if (!rst) begin
         state      <= ST_IDLE;
         rdy_q      <= 1'b1;
         page       <= '0;
         count      <= '0;
         data_latch <= '0;
      end else if (clk_phase_1) begin
         state <= state_nxt;
         case (state)
            ST_IDLE: begin
               if (trigger) begin
                  page  <= dma_bus.cpu_data_out;
                  count <= '0;
                  rdy_q <= 1'b0;
               end
            end
            ST_READ:  data_latch <= dma_bus.bus_data_in;
            ST_WRITE: begin
               count <= count + 8'd1;
               if (count == 8'hFF) rdy_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      dma_bus.dma_active   = 1'b0;
      dma_bus.bus_addr     = dma_bus.cpu_addr;
      dma_bus.bus_data_out = dma_bus.cpu_data_out;
      dma_bus.bus_write    = dma_bus.cpu_write;
      case (state)
         ST_ALIGN, ST_READ: begin
            dma_bus.dma_active = 1'b1;
            dma_bus.bus_addr   = {page, count};
            dma_bus.bus_write  = 1'b0;
         end
         ST_WRITE: begin
            dma_bus.dma_active   = 1'b1;
            dma_bus.bus_addr     = OAMDATA_REG;
            dma_bus.bus_data_out = data_latch;
            dma_bus.bus_write    = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_oam_dma_controller.sv
// tb_oam_dma_controller: randomized bench for oam_dma_controller. For each
// transfer the expected bus cycles are listed up front as a queue of
// operations (optional dummy, then 256 read/write pairs) and popped one per
// stalled CPU cycle; the stall length is checked against 513/514.
module tb_oam_dma_controller;

   logic sys_clock   = 1'b0;
   logic rst         = 1'b0;
   logic clk_phase_1 = 1'b0;

   oam_dma_controller_if dma_if ();

   oam_dma_controller dut (
      .sys_clock   (sys_clock),
      .rst         (rst),
      .clk_phase_1 (clk_phase_1),
      .dma_bus     (dma_if)
   );

   always #5 sys_clock = ~sys_clock;

   int checks     = 0;
   int failures   = 0;
   int strobe_cnt = 0;   // strobes since reset; its LSB is the cycle parity
   bit mem_identity = 1'b0;

   typedef struct {
      int          kind;  // 0 dummy, 1 read, 2 write
      logic [15:0] addr;
      logic [7:0]  data;
   } op_t;

   op_t exp_q[$];

   // Memory contents seen on bus_data_in
   function automatic logic [7:0] mem_byte(logic [15:0] a);
      if (mem_identity) return a[7:0];
      return (a[7:0] * 8'd7) ^ a[15:8] ^ 8'h5A;
   endfunction

   always_comb begin
      if (mem_identity) dma_if.bus_data_in = dma_if.bus_addr[7:0];
      else              dma_if.bus_data_in = (dma_if.bus_addr[7:0] * 8'd7) ^ dma_if.bus_addr[15:8] ^ 8'h5A;
   end

   task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic set_cpu(logic [15:0] a, logic [7:0] d, logic w, logic rc);
      dma_if.cpu_addr       = a;
      dma_if.cpu_data_out   = d;
      dma_if.cpu_write      = w;
      dma_if.cpu_read_cycle = rc;
   endtask

   task automatic check_passthru(string tag);
      check_eq({tag, "_dma_active"}, dma_if.dma_active, 0);
      check_eq({tag, "_addr"}, dma_if.bus_addr, dma_if.cpu_addr);
      check_eq({tag, "_wdata"}, dma_if.bus_data_out, dma_if.cpu_data_out);
      check_eq({tag, "_write"}, dma_if.bus_write, dma_if.cpu_write);
   endtask

   // Called at a negedge with inputs already set; leaves at a negedge.
   task automatic strobe_edge();
      clk_phase_1 = 1'b1;
      @(posedge sys_clock);
      strobe_cnt++;
      @(negedge sys_clock);
      clk_phase_1 = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge sys_clock);
   endtask

   task automatic idle_strobe();
      logic [15:0] a;
      a = 16'($urandom);
      if (a == 16'h4014) a = 16'h4015;
      set_cpu(a, 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      #1;
      check_eq("idle_rdy", dma_if.rdy, 1);
      check_passthru("idle");
      strobe_edge();
   endtask

   task automatic do_transfer(logic [7:0] page, int hold, bit want_align, bit inject, bit abort_at_40);
      int  stall;
      op_t op;
      logic [15:0] ra;
      // Choose the halt cycle's parity: a get-parity halt needs one ALIGN.
      if (((strobe_cnt + 1 + hold) % 2) != (want_align ? 0 : 1)) idle_strobe();

      set_cpu(16'h4014, page, 1'b1, 1'b0);
      #1;
      check_eq("trig_rdy", dma_if.rdy, 1);
      check_passthru("trig");
      strobe_edge();

      for (int h = 0; h < hold; h++) begin
         if (inject) set_cpu(16'h4014, ~page, 1'b1, 1'b0);
         else        set_cpu(16'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
         #1;
         check_eq("hold_rdy", dma_if.rdy, 0);
         check_passthru("hold");
         strobe_edge();
      end

      exp_q.delete();
      if (want_align) exp_q.push_back('{kind: 0, addr: 16'h0000, data: 8'h00});
      for (int i = 0; i < 256; i++) begin
         ra = {page, 8'(i)};
         exp_q.push_back('{kind: 1, addr: ra, data: 8'h00});
         exp_q.push_back('{kind: 2, addr: 16'h2004, data: mem_byte(ra)});
      end

      set_cpu(16'($urandom), 8'($urandom), 1'b0, 1'b1);
      #1;
      check_eq("halt_rdy", dma_if.rdy, 0);
      check_passthru("halt");
      stall = 1;
      strobe_edge();

      for (int n = 0; n < 600; n++) begin
         if (inject && exp_q.size() > 4 && $urandom_range(0, 7) == 0)
            set_cpu(16'h4014, 8'($urandom), 1'b1, 1'b1);
         else
            set_cpu(16'($urandom), 8'($urandom), 1'b0, 1'b1);
         #1;
         if (dma_if.rdy) break;
         stall++;
         if (exp_q.size() > 0) begin
            op = exp_q.pop_front();
            check_eq("op_dma_active", dma_if.dma_active, 1);
            check_eq("op_write", dma_if.bus_write, (op.kind == 2) ? 1 : 0);
            if (op.kind != 0) check_eq("op_addr", dma_if.bus_addr, op.addr);
            if (op.kind == 2) check_eq("op_wdata", dma_if.bus_data_out, op.data);
            if (abort_at_40 && op.kind == 1 && op.addr[7:0] == 8'h40) begin
               rst = 1'b0;
               clk_phase_1 = 1'($urandom_range(0, 1));
               @(posedge sys_clock);
               @(negedge sys_clock);
               rst = 1'b1;
               clk_phase_1 = 1'b0;
               strobe_cnt = 0;
               set_cpu(16'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
               #1;
               check_eq("abort_rdy", dma_if.rdy, 1);
               check_passthru("abort");
               repeat (4) idle_strobe();
               return;
            end
         end
         strobe_edge();
      end

      check_eq("stall_len", stall, want_align ? 514 : 513);
      check_eq("ops_left", exp_q.size(), 0);
      check_eq("end_rdy", dma_if.rdy, 1);
      check_passthru("end");
   endtask

   initial begin
      set_cpu(16'h0000, 8'h00, 1'b0, 1'b0);
      rst = 1'b0;
      repeat (3) begin
         @(negedge sys_clock);
         clk_phase_1 = 1'($urandom_range(0, 1));
      end
      @(negedge sys_clock);
      rst = 1'b1;
      clk_phase_1 = 1'b0;
      strobe_cnt = 0;
      set_cpu(16'h1234, 8'hA5, 1'b1, 1'b0);
      #1;
      check_eq("reset_rdy", dma_if.rdy, 1);
      check_passthru("reset");
      repeat (3) idle_strobe();

      do_transfer(8'h02, 0, 1'b0, 1'b0, 1'b0);
      do_transfer(8'h02, 0, 1'b1, 1'b0, 1'b0);
      do_transfer(8'h02, 3, 1'($urandom_range(0, 1)), 1'b0, 1'b0);

      mem_identity = 1'b1;
      do_transfer(8'hFF, 0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      mem_identity = 1'b0;

      do_transfer(8'($urandom), 1, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
      do_transfer(8'h02, 0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);

      repeat (2) do_transfer(8'($urandom), $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b1, 1'b0);

      repeat (2) idle_strobe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
